apb_cmd_master: RTL
===================

Name: apb_cmd_master

Overview:
- APB initiator that drives the control-register slave interface (psel/pen/pwr/paddr/pwdata/prdata) from a simple valid/ready command stream.
- Buffers commands in a small FIFO and issues fixed two-phase SETUP/ENABLE transfers, back-to-back when commands are queued.
- Returns one response per transfer, carrying read data for reads.
- Sits between the test/config sequencer side (or an embedded CPU bridge) and the MCDF control registers.

Parameters:
- ADDR_W, 8, APB address width (matches `ADDR_WIDTH).
- DATA_W, 32, APB data width (matches `CMD_DATA_WIDTH).
- CMD_DEPTH, 4, command FIFO depth; power of 2, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command FIFO can accept
- cmd_wr_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_W  register address
- cmd_wdata_i  in  DATA_W  write data (ignored for reads)
- psel_o  out  1  APB select
- pen_o  out  1  APB enable
- pwr_o  out  1  APB write
- paddr_o  out  ADDR_W  APB address
- pwdata_o  out  DATA_W  APB write data
- prdata_i  in  DATA_W  APB read data
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_wr_o  out  1  completed transfer was a write
- rsp_addr_o  out  ADDR_W  completed transfer's address
- rsp_rdata_o  out  DATA_W  read data; 0 for writes
- busy_o  out  1  FIFO non-empty or transfer in flight

Behaviour:
- Interface: one clock (clk_i); reset is asynchronous and active-high (rst_i).
- Reset values:
  - All outputs 0, except cmd_ready_o = 1.
  - FSM in IDLE; FIFO empty.
  - Reset asserted mid-transfer aborts it immediately: psel_o/pen_o drop asynchronously, queued commands are discarded, and no response is issued.
- Command accept:
  - A push occurs on a rising edge with cmd_valid_i & cmd_ready_o.
  - cmd_ready_o = !fifo_full, registered-flag based. There is no pass-through when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle are legal at any non-full level.
- FSM states: IDLE, SETUP, ENABLE. All APB outputs are registered.
  - IDLE -> SETUP when the FIFO is non-empty. The head entry is popped and loaded into paddr_o/pwr_o/pwdata_o on that edge.
  - SETUP -> ENABLE unconditionally; there is no pready and no wait states.
  - ENABLE -> SETUP when the FIFO is non-empty (pop and load the next entry). Otherwise ENABLE -> IDLE.
- APB output encoding:
  - psel_o = (state != IDLE); pen_o = (state == ENABLE).
  - paddr_o, pwr_o and pwdata_o are stable through SETUP and ENABLE. They hold their last values in IDLE; pwdata_o is forced to 0 for reads.
- Latency and throughput:
  - A command pushed at edge k into an empty FIFO with the FSM in IDLE gives SETUP during cycle k+1 and ENABLE during cycle k+2.
  - Sustained throughput is one transfer per 2 cycles.
- Response:
  - prdata_i is sampled at the edge ending ENABLE; the slave's read data is valid throughout ENABLE.
  - rsp_valid_o is high for exactly the one cycle following each ENABLE, with rsp_wr_o, rsp_addr_o and rsp_rdata_o of that transfer.
  - rsp_rdata_o is 0 when rsp_wr_o = 1.
  - There is no back-pressure on responses.
- busy_o = !fifo_empty | (state != IDLE).
- FIFO pointers use log2(CMD_DEPTH)+1 bits with wrap bit; full/empty are derived from the pointer compare.

Decomposition:
- Package / param_def additions:
  - APB state encoding (IDLE = 2'b00, SETUP = 2'b01, ENABLE = 2'b10), shared with the slave.
  - Command struct width constant: 1 + ADDR_W + DATA_W.
- Sub-module: cmd_fifo, a synchronous FIFO that is parameterised on width and depth and exposes full/empty.

Test Plan:
- Post-reset read of 8'h00 -> psel_o at cycle k+1, pen_o at k+2; rsp_valid_o at k+3 with rsp_rdata_o = 32'h00000007.
- Write 8'h04 with 32'h0000003B, then read 8'h04 -> APB write with pwr_o=1 and pwdata_o=32'h3B; read response rdata = 32'h0000003B (reserved bits masked by the slave).
- Push 4 commands in consecutive cycles (CMD_DEPTH=4):
  - cmd_ready_o deasserts only when the FIFO is full.
  - APB transfers run SETUP/ENABLE back-to-back with no IDLE gap.
  - 4 rsp_valid_o pulses arrive 2 cycles apart.
- Read 8'h10 with no channel traffic -> rsp_rdata_o = 32'h00000020 (FIFO margin).
- Assert rst_i during ENABLE with 2 commands queued:
  - psel_o/pen_o drop immediately and no rsp_valid_o is issued.
  - After release, busy_o = 0 and cmd_ready_o = 1.
- Hold cmd_valid_i=1 with the FIFO full while a pop occurs -> no push that cycle; the push lands on the next edge; the command order on paddr_o is preserved.

Source files
------------

// File: rtl/apb_cmd_master_pkg.sv
// Shared APB master definitions: transfer state encoding (common with the slave)
// and the packed command word width {wr, addr, wdata}.
package apb_cmd_master_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ENABLE = 2'b10
  } apb_state_e;

  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 32;
  localparam int CMD_DEPTH_DEF = 4;

  function automatic int cmd_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/apb_cmd_master_cmd_fifo.sv
// Synchronous FIFO with a combinational head read; push is dropped when full, pop when empty.
// Pointers carry an extra wrap bit so full/empty fall out of a plain compare.
module apb_cmd_master_cmd_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB initiator: queues valid/ready commands and issues back-to-back SETUP/ENABLE transfers,
// one registered response pulse per transfer. Command side stalls only on a full FIFO.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CMD_DEPTH = CMD_DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wr_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              psel_o,
  output logic              pen_o,
  output logic              pwr_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_wr_o,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              busy_o
);

  localparam int CMD_W = cmd_width(ADDR_W, DATA_W);

  apb_state_e        state;
  logic [CMD_W-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              head_wr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  assign cmd_ready_o = !fifo_full;
  assign busy_o      = !fifo_empty || (state != APB_IDLE);
  // A new transfer may start from IDLE or straight out of ENABLE.
  assign pop         = ((state == APB_IDLE) || (state == APB_ENABLE)) && !fifo_empty;

  assign head_wr    = head[CMD_W-1];
  assign head_addr  = head[CMD_W-2 -: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  apb_cmd_master_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (cmd_valid_i),
    .push_dat ({cmd_wr_i, cmd_addr_i, cmd_wdata_i}),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= APB_IDLE;
      psel_o      <= 1'b0;
      pen_o       <= 1'b0;
      pwr_o       <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_wr_o    <= 1'b0;
      rsp_addr_o  <= '0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        APB_SETUP: begin
          state <= APB_ENABLE;
          pen_o <= 1'b1;
        end
        APB_ENABLE: begin
          rsp_valid_o <= 1'b1;
          rsp_wr_o    <= pwr_o;
          rsp_addr_o  <= paddr_o;
          rsp_rdata_o <= pwr_o ? '0 : prdata_i;
          pen_o       <= 1'b0;
          if (pop) begin
            state    <= APB_SETUP;
            pwr_o    <= head_wr;
            paddr_o  <= head_addr;
            pwdata_o <= head_wr ? head_wdata : '0;
          end else begin
            state  <= APB_IDLE;
            psel_o <= 1'b0;
          end
        end
        default: begin
          if (pop) begin
            state    <= APB_SETUP;
            psel_o   <= 1'b1;
            pen_o    <= 1'b0;
            pwr_o    <= head_wr;
            paddr_o  <= head_addr;
            pwdata_o <= head_wr ? head_wdata : '0;
          end
        end
      endcase
    end
  end

endmodule
